// File: rtl/program_loader.sv
// Boot-time UART program loader: announces 0x99, receives a 32-bit size and the
// program bytes, writes big-endian packed words into imem, answers 0xAA, releases the CPU.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  tx_ready,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  busy,
   output logic                  boot_done,
   output logic                  error
);

   localparam int unsigned CW       = ADDR_WIDTH + 2;
   localparam logic [32:0] MAX_SIZE = 33'(64'd1 << CW);

   typedef enum logic [2:0] {
      S_INIT,
      S_SEND_99,
      S_RECV_SIZE,
      S_RECV_PROG,
      S_SEND_AA,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             size_q;
   logic [1:0]              size_cnt_q;
   logic [CW-1:0]           byte_cnt_q;
   logic [23:0]             word_q;
   logic                    last_wr_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;

   logic [31:0]             size_full;
   logic [31:0]             byte_next;
   logic                    last_byte;
   logic                    rx_size;
   logic                    rx_prog;

   assign size_full = {size_q[23:0], rx_data};
   // 32-bit compare so a maximum-size program is detected even though byte_cnt_q wraps
   assign byte_next = 32'(byte_cnt_q) + 32'd1;
   assign last_byte = (byte_next == size_q);
   assign rx_size   = (state_q == S_RECV_SIZE) && rx_valid;
   assign rx_prog   = (state_q == S_RECV_PROG) && rx_valid && !last_wr_q;

   always_comb begin
      state_d   = state_q;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      busy      = 1'b1;
      boot_done = 1'b0;
      error     = 1'b0;
      case (state_q)
         S_INIT: state_d = S_SEND_99;
         S_SEND_99: begin
            tx_valid = 1'b1;
            tx_data  = 8'h99;
            if (tx_ready) state_d = S_RECV_SIZE;
         end
         S_RECV_SIZE: begin
            if (rx_valid && size_cnt_q == 2'd3) begin
               if (size_full == 32'd0)
                  state_d = S_SEND_AA;
               else if (size_full[1:0] != 2'b00 || {1'b0, size_full} > MAX_SIZE)
                  state_d = S_ERROR;
               else
                  state_d = S_RECV_PROG;
            end
         end
         S_RECV_PROG: if (last_wr_q) state_d = S_SEND_AA;
         S_SEND_AA: begin
            tx_valid = 1'b1;
            tx_data  = 8'hAA;
            if (tx_ready) state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b0;
            boot_done = 1'b1;
         end
         S_ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_INIT;
         size_q     <= '0;
         size_cnt_q <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         last_wr_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= 1'b0;
         if (rx_size) begin
            size_q     <= size_full;
            size_cnt_q <= size_cnt_q + 2'd1;
         end
         if (rx_prog) begin
            byte_cnt_q <= byte_cnt_q + CW'(1);
            word_q     <= {word_q[15:0], rx_data};
            if (byte_cnt_q[1:0] == 2'd3) begin
               we_q      <= 1'b1;
               addr_q    <= byte_cnt_q[CW-1:2];
               wdata_q   <= {word_q, rx_data};
               last_wr_q <= last_byte;
            end
         end
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;

endmodule
